// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
// Also intended for the matching transmit side.
package uart_pkg;

  typedef enum logic [1:0] {
    PM_NONE = 2'b00,
    PM_EVEN = 2'b01,
    PM_ODD  = 2'b10,
    PM_RSVD = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } rx_state_t;

  localparam int ERR_BREAK  = 0;
  localparam int ERR_PARITY = 1;
  localparam int ERR_FRAME  = 2;

  // Rounded clock divider for the oversampling tick, never below 1.
  function automatic int calc_div(input int sysclk, input int baud, input int os);
    int d;
    d = (sysclk + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and a
// sticky overflow flag. Head entry is registered; empty reads as zero.
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         srst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] head_reg;
  logic             ovf_reg;
  logic             pop, push_ok;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign pop      = rd_en & ~empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push_ok  = wr_en & (~full | pop);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign count_next  = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

  assign rd_data  = head_reg;
  assign count    = count_reg;
  assign overflow = ovf_reg;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_ok);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (wr_en & full & ~pop) ovf_reg <= 1'b1;
      // Bypass the array when the next head is the entry being written now.
      if (count_next == '0)
        head_reg <= '0;
      else if (push_ok && (wr_ptr_reg == rd_ptr_next))
        head_reg <= wr_data;
      else
        head_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronizer, tick divider, frame FSM with
// parity/stop/break detection, and a status-carrying FWFT receive FIFO.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int SYSCLK_RATE = 100000000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int RTS_MARGIN  = 2
) (
  input  logic                              SysClk,
  input  logic                              Rst,
  input  logic                              Rx,
  input  logic [1:0]                        Parity_Mode,
  input  logic                              Stop_Sel,
  input  logic                              Read_Done,
  output logic [DATA_BITS-1:0]              Data_Out,
  output logic [2:0]                        Rx_Error,
  output logic                              Data_Rdy,
  output logic                              FIFO_Empty,
  output logic                              FIFO_Full,
  output logic                              FIFO_Overflow,
  output logic                              RTS,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   Count,
  output logic                              Rx_Busy
);

  localparam int DIV   = calc_div(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int DIV_W = $clog2(DIV+1);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam int ENT_W = DATA_BITS + 3;

  logic                sync1_reg, sync2_reg, rx_s;
  logic [DIV_W-1:0]    div_cnt_reg;
  logic                tick;
  rx_state_t           state_reg;
  logic [OS_W-1:0]     os_cnt_reg;
  logic [BIT_W-1:0]    bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  parity_mode_t        mode_reg;
  logic                two_stop_reg, stop_idx_reg;
  logic                par_bit_reg, par_err_reg, frame_err_reg;
  logic                push_reg;
  logic [ENT_W-1:0]    push_data_reg;
  logic [ENT_W-1:0]    head;
  logic                rts_reg;
  logic                par_en, full_pt, half_pt, is_break;
  logic [2:0]          err_normal, err_break;

  assign rx_s    = sync2_reg;
  assign tick    = (div_cnt_reg == DIV_W'(DIV - 1));
  assign full_pt = tick && (os_cnt_reg == OS_W'(OVERSAMPLE - 1));
  assign half_pt = tick && (os_cnt_reg == OS_W'(OVERSAMPLE/2 - 1));
  assign par_en  = (mode_reg == PM_EVEN) || (mode_reg == PM_ODD);
  // par_bit_reg is cleared at frame start, so it is 0 when parity is off.
  assign is_break = !stop_idx_reg && (shift_reg == '0) && !par_bit_reg && !rx_s;

  always_comb begin
    err_normal             = 3'b000;
    err_normal[ERR_FRAME]  = frame_err_reg | ~rx_s;
    err_normal[ERR_PARITY] = par_err_reg;
    err_break              = 3'b000;
    err_break[ERR_BREAK]   = 1'b1;
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      div_cnt_reg <= '0;
    end else begin
      sync1_reg   <= Rx;
      sync2_reg   <= sync1_reg;
      div_cnt_reg <= tick ? '0 : div_cnt_reg + DIV_W'(1);
    end
  end

  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_reg     <= S_IDLE;
      os_cnt_reg    <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      mode_reg      <= PM_NONE;
      two_stop_reg  <= 1'b0;
      stop_idx_reg  <= 1'b0;
      par_bit_reg   <= 1'b0;
      par_err_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      push_reg      <= 1'b0;
      push_data_reg <= '0;
    end else begin
      push_reg <= 1'b0;
      if (tick) os_cnt_reg <= full_pt ? '0 : os_cnt_reg + OS_W'(1);
      case (state_reg)
        S_IDLE: begin
          if (tick && !rx_s) begin
            state_reg     <= S_START;
            os_cnt_reg    <= '0;
            bit_cnt_reg   <= '0;
            mode_reg      <= parity_mode_t'(Parity_Mode);
            two_stop_reg  <= Stop_Sel;
            stop_idx_reg  <= 1'b0;
            par_bit_reg   <= 1'b0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
          end
        end
        S_START: begin
          if (half_pt) begin
            os_cnt_reg <= '0;
            state_reg  <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (full_pt) begin
            shift_reg   <= {shift_reg[DATA_BITS-2:0], rx_s};
            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1))
              state_reg <= par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (full_pt) begin
            par_bit_reg <= rx_s;
            par_err_reg <= rx_s ^ (^shift_reg) ^ (mode_reg == PM_ODD);
            state_reg   <= S_STOP;
          end
        end
        S_STOP: begin
          if (full_pt) begin
            if (is_break) begin
              push_reg      <= 1'b1;
              push_data_reg <= {err_break, {DATA_BITS{1'b0}}};
              state_reg     <= S_BREAK_WAIT;
            end else if (!stop_idx_reg && two_stop_reg) begin
              frame_err_reg <= ~rx_s;
              stop_idx_reg  <= 1'b1;
            end else begin
              push_reg      <= 1'b1;
              push_data_reg <= {err_normal, shift_reg};
              state_reg     <= S_IDLE;
            end
          end
        end
        S_BREAK_WAIT: begin
          if (rx_s) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (SysClk),
    .srst     (Rst),
    .wr_en    (push_reg),
    .wr_data  (push_data_reg),
    .rd_en    (Read_Done),
    .rd_data  (head),
    .count    (Count),
    .full     (FIFO_Full),
    .empty    (FIFO_Empty),
    .overflow (FIFO_Overflow)
  );

  always_ff @(posedge SysClk) begin
    if (Rst) rts_reg <= 1'b1;
    else     rts_reg <= (Count < CNT_W'(FIFO_DEPTH - RTS_MARGIN));
  end

  assign Data_Out = head[DATA_BITS-1:0];
  assign Rx_Error = head[DATA_BITS +: 3];
  assign Data_Rdy = ~FIFO_Empty;
  assign RTS      = rts_reg;
  assign Rx_Busy  = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=1 (16 clocks per bit): table of
// single frames, then break, FIFO fill/overflow, glitch and reset sequences.
module tb_uart_rx_os;

  localparam int BIT_CYC = 16;

  logic       SysClk = 1'b0;
  logic       Rst, Rx, Stop_Sel, Read_Done;
  logic [1:0] Parity_Mode;
  logic [7:0] Data_Out;
  logic [2:0] Rx_Error;
  logic       Data_Rdy, FIFO_Empty, FIFO_Full, FIFO_Overflow, RTS, Rx_Busy;
  logic [3:0] Count;

  int checks = 0;
  int errors = 0;

  always #5 SysClk = ~SysClk;

  uart_rx_os #(
    .SYSCLK_RATE (1600000),
    .BAUD_RATE   (100000),
    .OVERSAMPLE  (16),
    .DATA_BITS   (8),
    .FIFO_DEPTH  (8),
    .RTS_MARGIN  (2)
  ) dut (
    .SysClk        (SysClk),
    .Rst           (Rst),
    .Rx            (Rx),
    .Parity_Mode   (Parity_Mode),
    .Stop_Sel      (Stop_Sel),
    .Read_Done     (Read_Done),
    .Data_Out      (Data_Out),
    .Rx_Error      (Rx_Error),
    .Data_Rdy      (Data_Rdy),
    .FIFO_Empty    (FIFO_Empty),
    .FIFO_Full     (FIFO_Full),
    .FIFO_Overflow (FIFO_Overflow),
    .RTS           (RTS),
    .Count         (Count),
    .Rx_Busy       (Rx_Busy)
  );

  typedef struct {
    logic [1:0] mode;
    logic       two;
    logic [7:0] data;
    logic       pb;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge SysClk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame(input logic [1:0] mode, input logic two, input logic [7:0] d,
                            input logic pb, input logic s0, input logic s1);
    Parity_Mode = mode;
    Stop_Sel    = two;
    drive_bit(1'b0);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    if (mode == 2'b01 || mode == 2'b10) drive_bit(pb);
    drive_bit(s0);
    if (two) drive_bit(s1);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic pop();
    Read_Done = 1'b1;
    wait_cyc(1);
    Read_Done = 1'b0;
  endtask

  initial begin
    //            mode   two   data   pb    s0    s1    exp_data exp_err
    vecs[0] = '{2'b01, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 3'b000};
    vecs[1] = '{2'b10, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 8'hAA, 3'b010};
    vecs[2] = '{2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 3'b100};
    vecs[3] = '{2'b01, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 3'b000};
    vecs[4] = '{2'b01, 1'b0, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 3'b010};
    vecs[5] = '{2'b10, 1'b1, 8'h81, 1'b1, 1'b1, 1'b0, 8'h81, 3'b100};
    vecs[6] = '{2'b11, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 3'b000};
    vecs[7] = '{2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 3'b001};
    vecs[8] = '{2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 3'b110};

    Rst = 1'b1; Rx = 1'b1; Read_Done = 1'b0; Parity_Mode = 2'b00; Stop_Sel = 1'b0;
    wait_cyc(4);
    chk("rst_data", Data_Out, 0);
    chk("rst_err", Rx_Error, 0);
    chk("rst_rdy", Data_Rdy, 0);
    chk("rst_empty", FIFO_Empty, 1);
    chk("rst_full", FIFO_Full, 0);
    chk("rst_ovf", FIFO_Overflow, 0);
    chk("rst_rts", RTS, 1);
    chk("rst_count", Count, 0);
    chk("rst_busy", Rx_Busy, 0);
    Rst = 1'b0;
    wait_cyc(4);

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].mode, vecs[v].two, vecs[v].data, vecs[v].pb, vecs[v].s0, vecs[v].s1);
      $display("vec %0d: data 0x%02h err %03b count %0d", v, Data_Out, Rx_Error, Count);
      chk($sformatf("vec%0d_count", v), Count, 1);
      chk($sformatf("vec%0d_rdy", v), Data_Rdy, 1);
      chk($sformatf("vec%0d_data", v), Data_Out, vecs[v].exp_data);
      chk($sformatf("vec%0d_err", v), Rx_Error, vecs[v].exp_err);
      pop();
      chk($sformatf("vec%0d_empty", v), FIFO_Empty, 1);
      chk($sformatf("vec%0d_data0", v), Data_Out, 0);
    end

    // Long break: exactly one break entry, then a clean character
    Parity_Mode = 2'b00; Stop_Sel = 1'b0;
    Rx = 1'b0;
    wait_cyc(40 * BIT_CYC);
    $display("break: data 0x%02h err %03b count %0d", Data_Out, Rx_Error, Count);
    chk("brk_count", Count, 1);
    chk("brk_data", Data_Out, 8'h00);
    chk("brk_err", Rx_Error, 3'b001);
    chk("brk_busy", Rx_Busy, 1);
    Rx = 1'b1;
    wait_cyc(2 * BIT_CYC);
    chk("brk_count_after", Count, 1);
    chk("brk_idle", Rx_Busy, 0);
    pop();
    send_frame(2'b00, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1);
    $display("after break: data 0x%02h err %03b", Data_Out, Rx_Error);
    chk("post_brk_data", Data_Out, 8'h55);
    chk("post_brk_err", Rx_Error, 3'b000);
    pop();

    // Fill to full, overflow, then drain in order
    for (int i = 0; i < 8; i++) begin
      send_frame(2'b00, 1'b0, 8'(i), 1'b0, 1'b1, 1'b1);
      $display("fill %0d: count %0d rts %0b full %0b", i, Count, RTS, FIFO_Full);
      chk($sformatf("fill%0d_count", i), Count, i + 1);
      chk($sformatf("fill%0d_rts", i), RTS, (i + 1 < 6) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), FIFO_Full, (i + 1 == 8) ? 1 : 0);
    end
    chk("pre_ovf", FIFO_Overflow, 0);
    send_frame(2'b00, 1'b0, 8'h08, 1'b0, 1'b1, 1'b1);
    $display("overflow: ovf %0b count %0d", FIFO_Overflow, Count);
    chk("ovf_flag", FIFO_Overflow, 1);
    chk("ovf_count", Count, 8);
    for (int i = 0; i < 8; i++) begin
      $display("drain %0d: data 0x%02h", i, Data_Out);
      chk($sformatf("drain%0d_data", i), Data_Out, i);
      pop();
    end
    wait_cyc(2);
    chk("drain_empty", FIFO_Empty, 1);
    chk("drain_ovf_sticky", FIFO_Overflow, 1);
    chk("drain_rts", RTS, 1);

    // Short glitch: start detected, then rejected
    Rx = 1'b0;
    wait_cyc(8);
    Rx = 1'b1;
    chk("glitch_busy", Rx_Busy, 1);
    wait_cyc(2 * BIT_CYC);
    $display("glitch: busy %0b count %0d", Rx_Busy, Count);
    chk("glitch_idle", Rx_Busy, 0);
    chk("glitch_count", Count, 0);

    // Reset in the middle of a data phase
    send_frame(2'b00, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b1);
    chk("prerst_count", Count, 1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("prerst_busy", Rx_Busy, 1);
    Rst = 1'b1;
    wait_cyc(1);
    Rst = 1'b0;
    Rx = 1'b1;
    chk("rst_mid_count", Count, 0);
    chk("rst_mid_busy", Rx_Busy, 0);
    chk("rst_mid_ovf", FIFO_Overflow, 0);
    wait_cyc(12 * BIT_CYC);
    $display("mid-frame reset: count %0d empty %0b", Count, FIFO_Empty);
    chk("rst_mid_count_late", Count, 0);
    chk("rst_mid_empty", FIFO_Empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receive path. It replaces the baud-clock-driven receiver with a single-SysClk design that uses an internal oversampling tick. Parity mode and stop-bit count are selectable at runtime. Received characters land in a first-word-fall-through FIFO, and each entry carries its own error status. The block sits between the Rx pin and the host read interface (Read_Done/Data_Out) and also drives RTS flow control.

Parameters:
SYSCLK_RATE, 100000000, SysClk frequency in Hz
BAUD_RATE, 9600, line rate in baud
OVERSAMPLE, 16, ticks per bit; even, >=4
DATA_BITS, 8, data bits per character
FIFO_DEPTH, 8, entries; power of 2, >=2
RTS_MARGIN, 2, RTS deasserts when Count >= FIFO_DEPTH-RTS_MARGIN

Ports:
SysClk  in  1  single clock; all logic on posedge
Rst  in  1  reset; synchronous, active-high
Rx  in  1  serial input; asynchronous, idle high
Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
Stop_Sel  in  1  0 = one stop bit, 1 = two stop bits
Read_Done  in  1  pops one FIFO entry per cycle it is high
Data_Out  out  DATA_BITS  head entry data
Rx_Error  out  3  head entry status: [0] break, [1] parity, [2] frame
Data_Rdy  out  1  FIFO not empty
FIFO_Empty  out  1  FIFO empty
FIFO_Full  out  1  FIFO full
FIFO_Overflow  out  1  sticky: a character was dropped
RTS  out  1  1 = peer may send
Count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
Rx_Busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: Data_Out 0, Rx_Error 0, Data_Rdy 0, FIFO_Empty 1, FIFO_Full 0, FIFO_Overflow 0, RTS 1, Count 0, Rx_Busy 0. Synchronizer flops reset to 1. FSM resets to IDLE. Divider and sample counters reset to 0.
- Rx passes through a 2-flop synchronizer (2 cycles of latency). All references to Rx below mean the synchronized value.
- Tick generator:
  - DIV = round(SYSCLK_RATE/(BAUD_RATE*OVERSAMPLE)), clamped to >=1.
  - One-cycle tick every DIV cycles; free-running.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. Sample counter advances on ticks only.
  - IDLE: on a tick with Rx=0, go to START and clear the counter. Latch Parity_Mode and Stop_Sel here; they are held for the whole frame.
  - START: sample at tick OVERSAMPLE/2. If Rx=1, it is a false start: return to IDLE with no push. Otherwise go to DATA.
  - DATA: sample every OVERSAMPLE ticks. DATA_BITS samples, shifted in MSB first. Then go to PARITY if the mode is even or odd, else to STOP.
  - PARITY: even parity means the bit equals XOR of the data bits; odd means its inverse. A mismatch sets the parity flag.
  - STOP: take one or two samples. Any 0 sets the frame flag.
  - Push happens in the cycle of the final stop sample (mid-bit). Then go to IDLE, so the next start edge is detectable during the remaining half stop bit.
  - Break: if data is all zeros, parity (when enabled) is 0, and the first stop sample is 0, push data 0 with status 001. Parity and frame flags are suppressed. Go to BREAK_WAIT; skip any second stop sample.
  - BREAK_WAIT: stay until Rx=1, then go to IDLE.
- FIFO:
  - Entry width DATA_BITS+3. First-word fall-through: a pushed entry appears on Data_Out/Rx_Error on the next cycle when the FIFO was empty.
  - When empty, Data_Out and Rx_Error read 0.
  - Read_Done while empty is ignored.
  - Push and pop in the same cycle: both take effect and Count is unchanged. This also applies when full; no overflow results.
  - Push while full with no pop: the character is dropped and FIFO_Overflow is set until Rst.
  - Pointers wrap modulo FIFO_DEPTH.
- RTS = (Count < FIFO_DEPTH-RTS_MARGIN), registered. It does not affect reception.
- Rst mid-frame: the frame is abandoned with no push, the FIFO is cleared, and the FSM returns to IDLE.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum
  - rx_state_t enum
  - error bit index constants ERR_BREAK=0, ERR_PARITY=1, ERR_FRAME=2
  - function calc_div(sysclk, baud, os)
- One sub-module, uart_sync_fifo: parametrised WIDTH and DEPTH, FWFT, with Count/Full/Empty/Overflow. Future TX-side reuse is intended.

Test Plan:
All scenarios use SYSCLK_RATE=1600000, BAUD_RATE=100000, OVERSAMPLE=16, giving DIV=1 and a 16-cycle bit.
- Parity_Mode=01, Stop_Sel=1, send 0xA5 with parity 0 and two stop bits -> Data_Out=0xA5, Rx_Error=000, Data_Rdy=1.
- Parity_Mode=10, send 0xAA with parity bit 0 -> Rx_Error=010 (odd expects 1); Data_Out=0xAA.
- Parity_Mode=00, Stop_Sel=0, send 0x3C with stop bit 0 -> Rx_Error=100.
- Rx held low for 40 bit times -> exactly one entry with Data_Out=0x00 and Rx_Error=001. No further pushes until Rx returns high; then 0x55 is received cleanly.
- Send 0x00..0x07 with no reads -> FIFO_Full=1 and RTS=0 from Count=6 onward. A 9th character 0x08 sets FIFO_Overflow=1 and is dropped. Reads return 0x00..0x07 in order.
- 8-cycle low glitch on idle Rx -> no push and FSM back in IDLE. A Rst pulse mid-DATA -> Count=0 and no entry pushed.
